// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle EX-stage ALU with valid/ready handshakes and iterative 1-bit/cycle shifts.
// Define BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);
`ifdef BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state, state_n;
  logic accept, legal;
  logic [SW-1:0] shamt;
  logic [XLEN-1:0] alu_out;
  assign accept    = in_valid & in_ready;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign shamt     = op_b[SW-1:0];
  assign legal     = alu_ctrl inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100,
                                      4'b1000, 4'b1001, 4'b1010, 4'b0111, 4'b1011};
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'b0010: alu_out = op_a + op_b;
      4'b0110: alu_out = op_a - op_b;
      4'b0000: alu_out = op_a & op_b;
      4'b0001: alu_out = op_a | op_b;
      4'b0100: alu_out = op_a ^ op_b;
      4'b0111: alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b1011: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
`ifdef BARREL_SHIFT_EN
      4'b1000: alu_out = op_a << shamt;
      4'b1001: alu_out = op_a >> shamt;
      4'b1010: alu_out = $unsigned($signed(op_a) >>> shamt);
`else
      // only reached here with shamt==0; nonzero amounts go through SHIFT
      4'b1000, 4'b1001, 4'b1010: alu_out = op_a;
`endif
      default: alu_out = '0;
    endcase
  end
`ifdef BARREL_SHIFT_EN
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? DONE : IDLE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        result  <= alu_out;
        zero    <= alu_out == '0;
        illegal <= !legal;
      end
    end
  end
`else
  logic is_shift, long_shift;
  logic [1:0] kind;
  logic [SW-1:0] cnt;
  logic [XLEN-1:0] work, work_sh;
  assign is_shift   = alu_ctrl inside {4'b1000, 4'b1001, 4'b1010};
  assign long_shift = is_shift && shamt != '0;
  // kind: 00 sll, 01 srl, 10 sra
  assign work_sh = kind == 2'b00 ? {work[XLEN-2:0], 1'b0} : {kind[1] & work[XLEN-1], work[XLEN-1:1]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (long_shift ? SHIFT : DONE) : IDLE;
      SHIFT:   state_n = cnt == SW'(1) ? DONE : SHIFT;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      kind    <= '0;
      cnt     <= '0;
      work    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        kind <= alu_ctrl[1:0];
        cnt  <= shamt;
        work <= op_a;
        if (!long_shift) begin
          result  <= alu_out;
          zero    <= alu_out == '0;
          illegal <= !legal;
        end
      end
      if (state == SHIFT) begin
        work <= work_sh;
        cnt  <= cnt - SW'(1);
        if (cnt == SW'(1)) begin
          result  <= work_sh;
          zero    <= work_sh == '0;
          illegal <= 1'b0;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, zero, illegal;
  logic [3:0] alu_ctrl = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  int checks = 0, failures = 0;
`ifdef BARREL_SHIFT_EN
  localparam bit BAR = 1;
`else
  localparam bit BAR = 0;
`endif
  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  function automatic int exp_lat(input int n);
    return (BAR || n == 0) ? 1 : n + 1;
  endfunction
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in_valid = 1; alu_ctrl = c; op_a = a; op_b = b;
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    @(negedge clk);
    in_valid = 0; alu_ctrl = 4'b0010; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0005;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", {31'b0, out_valid}, 1);
  endtask
  task automatic consume();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] r, input int n);
    int lat;
    issue(c, a, b, lat);
    chk({tag, "_lat"}, lat, exp_lat(n));
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, r == 0});
    chk({tag, "_ill"}, {31'b0, illegal}, 0);
    consume();
  endtask
  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {30'b0, zero, illegal}, 0);
    reset = 0;
    op("add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    op("sub", 4'b0110, 32'h1234, 32'h1234, 32'h0, 0);
    op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
    op("sltu", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    op("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 0);
    op("or", 4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 0);
    op("xor", 4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0, 0);
    op("sra", 4'b1010, 32'h8000_0000, 32'h4, 32'hF800_0000, 4);
    op("srl", 4'b1001, 32'h8000_0000, 32'h21, 32'h4000_0000, 1);
    op("sll31", 4'b1000, 32'h1, 32'h1F, 32'h8000_0000, 31);
    op("sll0", 4'b1000, 32'hABCD, 32'h20, 32'hABCD, 0);
    op("sll_out", 4'b1000, 32'hC000_0000, 32'h2, 32'h0, 2);
    issue(4'b1111, 32'h55, 32'h66, lat);
    chk("ill_lat", lat, 1);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("ill_hold_valid", {31'b0, out_valid}, 1);
      chk("ill_hold_ready", {31'b0, in_ready}, 0);
      chk("ill_hold_res", result, 0);
      chk("ill_hold_flags", {30'b0, zero, illegal}, 32'h3);
      @(negedge clk);
    end
    in_valid = 0;
    consume();
    chk("post_hs_ready", {31'b0, in_ready}, 1);
    chk("post_hs_valid", {31'b0, out_valid}, 0);
    chk("post_hs_flags", {30'b0, zero, illegal}, 32'h3);
    op("add_after_ill", 4'b0010, 32'h5, 32'h6, 32'hB, 0);
    @(negedge clk);
    in_valid = 1; alu_ctrl = 4'b1000; op_a = 32'h1; op_b = 32'h1F;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    if (!BAR) chk("mid_shift_busy", {31'b0, out_valid}, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_ready", {31'b0, in_ready}, 1);
    chk("mid_rst_result", result, 0);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_result", {31'b0, out_valid}, 0);
    op("recover", 4'b0110, 32'h10, 32'h3, 32'hD, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
